// File: rtl/regs_wb_pkg.sv
// Shared constants, entry type and lane helpers for the register write-back scheduler.
package regs_wb_pkg;

  localparam int REG_ADDR_W   = 3;
  localparam int REG_DATA_W   = 16;
  localparam int WB_IN_LANES  = 4;
  localparam int WB_OUT_LANES = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

  // Number of leading ones from bit 0; anything past the first zero is ignored.
  function automatic logic [2:0] lead_ones(input logic [WB_IN_LANES-1:0] v);
    logic [2:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int k = 0; k < WB_IN_LANES; k++) begin
      if (run && v[k]) n = n + 3'd1;
      else run = 1'b0;
    end
    return n;
  endfunction

endpackage

// File: rtl/regs_wb_fifo.sv
// Multi-write / multi-read circular buffer: IN_N packed pushes and OUT_N pops per cycle.
// Pushed words must be packed from lane 0; storage itself is never reset.
module regs_wb_fifo
  import regs_wb_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int W     = REG_ADDR_W + REG_DATA_W,
  parameter  int IN_N  = WB_IN_LANES,
  parameter  int OUT_N = WB_OUT_LANES,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1,
  localparam int IN_W  = $clog2(IN_N + 1),
  localparam int OUT_W = $clog2(OUT_N + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IN_W-1:0]    push_n,
  input  logic [IN_N*W-1:0]  push_data,
  input  logic [OUT_W-1:0]   pop_n,
  output logic [OUT_N*W-1:0] head_data,
  output logic [CNT_W-1:0]   count
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q + PTR_W'(pop_n);
    tail_d  = tail_q + PTR_W'(push_n);
    count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < IN_N; k++) begin
      if (IN_W'(k) < push_n) mem_q[tail_q + PTR_W'(k)] <= push_data[k*W +: W];
    end
  end

  always_comb begin
    head_data = '0;
    for (int j = 0; j < OUT_N; j++) begin
      head_data[j*W +: W] = mem_q[head_q + PTR_W'(j)];
    end
  end

  assign count = count_q;

endmodule

// File: rtl/regs_wb_sched.sv
// Write-back scheduler: buffers up to 4 in-order commits per cycle, drains 2 per cycle to the regfile.
// Optional cut-through from input lanes to write ports on an empty queue: REGS_WB_BYPASS_EN.
module regs_wb_sched
  import regs_wb_pkg::*;
#(
  parameter  int DEPTH  = 8,
  parameter  int DATA_W = REG_DATA_W,
  parameter  int ADDR_W = REG_ADDR_W,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [WB_IN_LANES-1:0]          in_valid,
  input  logic [WB_IN_LANES*ADDR_W-1:0]   in_waddr,
  input  logic [WB_IN_LANES*DATA_W-1:0]   in_wdata,
  output logic                            in_ready,
  output logic                            wen0,
  output logic [ADDR_W-1:0]               waddr0,
  output logic [DATA_W-1:0]               wdata0,
  output logic                            wen1,
  output logic [ADDR_W-1:0]               waddr1,
  output logic [DATA_W-1:0]               wdata1,
  output logic [CNT_W-1:0]                count,
  output logic                            idle
);

  localparam int W = ADDR_W + DATA_W;

  logic [WB_IN_LANES*W-1:0]  lanes;
  logic [WB_OUT_LANES*W-1:0] head_data;
  logic [CNT_W-1:0]          count_w;
  logic [2:0]                n_in, n_acc, push_n;
  logic [1:0]                pop_n;
  logic                      accept;
  logic [WB_IN_LANES*W-1:0]  push_data;
  logic                      en0, en1;
  logic [W-1:0]              src0, src1;

  always_comb begin
    lanes = '0;
    for (int k = 0; k < WB_IN_LANES; k++) begin
      lanes[k*W +: W] = {in_waddr[k*ADDR_W +: ADDR_W], in_wdata[k*DATA_W +: DATA_W]};
    end
  end

  // Ready looks only at the registered count so the ROB never sees a loop through in_valid.
  assign in_ready = (count_w <= CNT_W'(DEPTH - WB_IN_LANES));
  assign n_in     = lead_ones(in_valid);
  assign accept   = in_ready & in_valid[0];
  assign n_acc    = accept ? n_in : 3'd0;

  always_comb begin
    if (count_w >= CNT_W'(2))  pop_n = 2'd2;
    else if (count_w != '0)    pop_n = 2'd1;
    else                       pop_n = 2'd0;
  end

  always_comb begin
    en0       = (pop_n != 2'd0);
    en1       = (pop_n == 2'd2);
    src0      = head_data[0 +: W];
    src1      = head_data[W +: W];
    push_n    = n_acc;
    push_data = lanes;
`ifdef REGS_WB_BYPASS_EN
    // Empty queue: the two oldest lanes go straight to the ports, the rest queue behind them.
    if (accept && (count_w == '0)) begin
      en0       = 1'b1;
      en1       = (n_acc >= 3'd2);
      src0      = lanes[0 +: W];
      src1      = lanes[W +: W];
      push_n    = (n_acc > 3'd2) ? (n_acc - 3'd2) : 3'd0;
      push_data = {{(2*W){1'b0}}, lanes[WB_IN_LANES*W-1:2*W]};
    end
`endif
    wen0   = en0;
    waddr0 = en0 ? src0[W-1:DATA_W] : '0;
    wdata0 = en0 ? src0[DATA_W-1:0] : '0;
    wen1   = en1;
    waddr1 = en1 ? src1[W-1:DATA_W] : '0;
    wdata1 = en1 ? src1[DATA_W-1:0] : '0;
  end

  regs_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (W),
    .IN_N  (WB_IN_LANES),
    .OUT_N (WB_OUT_LANES)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_n    (push_n),
    .push_data (push_data),
    .pop_n     (pop_n),
    .head_data (head_data),
    .count     (count_w)
  );

  assign count = count_w;
  assign idle  = (count_w == '0);

endmodule
